uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- UART receiver: 8N1 asynchronous serial in, parallel byte out.
- LSB first, 1 start bit, 8 data bits, 1 stop bit.
- Mid-bit sampling driven by a baud timer derived from the clock frequency.
- Sits between the board RX pin and the byte consumer; it is the counterpart of the team's uart_tx_ctrl on the same link.

Parameters:
- BAUD, 115200, line rate in bits/s.
- CLOCK_SPEED, 100_000_000, clk frequency in Hz.
- CNTR_WIDTH, 18, width of the baud timer. Must hold BIT_TIMER = CLOCK_SPEED/BAUD (integer division; 868 at defaults).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- uart_rx  input  1  asynchronous serial line, idle high.
- data  output  8  last good received byte; held until the next good frame.
- valid  output  1  one-cycle pulse; data is updated in the same cycle.
- frame_err  output  1  one-cycle pulse; stop bit sampled low.
- parity_err  output  1  one-cycle pulse; see Optional Feature. Constant 0 when the feature is off.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - Outputs: data=0, valid=0, frame_err=0, parity_err=0, busy=0.
  - Internal: state=IDLE, timer=0, bit_index=0, both synchronizer flops=1.
- Reset mid-frame aborts the frame immediately. No pulse is issued for the partial frame.
- Input path: uart_rx passes through a 2-flop synchronizer giving rx_s. All decisions use rx_s, so pin-to-rx_s latency is 2 cycles.
- Constants: HALF_TIMER = BIT_TIMER/2 (truncated).
- timer:
  - Increments by 1 per cycle in timed states.
  - Is cleared on every state transition and on each sample.
  - Never wraps; CNTR_WIDTH is the integrator's responsibility.
- States:
  - IDLE:
    - timer=0, bit_index=0.
    - rx_s==0 -> START.
  - START:
    - At timer==HALF_TIMER, sample rx_s.
    - rx_s==0 -> DATA.
    - rx_s==1 (glitch/false start) -> IDLE with no pulse.
  - DATA:
    - At timer==BIT_TIMER-1, sample: shift register <= {rx_s, shift[7:1]}, bit_index+1.
    - After the 8th sample (bit_index==7 at the sample) -> STOP, or PARITY if the feature is on.
  - STOP:
    - At timer==BIT_TIMER-1, sample.
    - rx_s==1: data<=shift, valid=1 for one cycle -> IDLE.
    - rx_s==0: frame_err=1 for one cycle, data unchanged -> BREAK.
  - BREAK:
    - Wait for rx_s==1, then -> IDLE. A held-low line (break) produces exactly one frame_err, not repeated frames.
  - Any illegal state encoding -> IDLE.
- valid and frame_err are never high in the same cycle.
- There is no backpressure and no overrun flag. The consumer must capture data on valid; a later good frame overwrites it.
- A new start edge is accepted on the cycle after the return to IDLE, so back-to-back frames with a full stop bit are received without loss.
- Latency: valid asserts 2 + 1 + HALF_TIMER + 9*BIT_TIMER (±1) cycles after the falling edge of the start bit at the pin.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1.
  - After the 8 data bits, state PARITY samples one bit at timer==BIT_TIMER-1, then -> STOP.
  - Parity is even: XOR of the 8 data bits and the parity bit must be 0.
  - Mismatch: at the STOP sample, if the stop bit is 1, parity_err pulses one cycle and valid does NOT pulse; data is unchanged.
  - If the stop bit is 0, only frame_err pulses.
- Undefined:
  - PARITY state and parity logic are absent.
  - parity_err is tied 0.
  - Frame is 8N1.

Test Plan (bench parameters: CLOCK_SPEED=1_000_000, BAUD=100_000, so BIT_TIMER=10, HALF_TIMER=5):
- Reset then idle line high for 100 cycles -> data=0x00, valid/frame_err/busy stay 0.
- Send 0xA5 (8N1, 10 cycles/bit) -> single valid pulse with data=0xA5, busy falls with it. Check the valid cycle against the latency formula.
- Send 0x00 then 0xFF back-to-back, no idle gap -> two valid pulses with data 0x00 then 0xFF. No frame_err.
- Low glitch of 3 cycles on idle line -> START aborts, no pulse, busy returns to 0 within 8 cycles.
- Frame 0x3C with stop bit driven 0, then line held low for 50 cycles -> exactly one frame_err pulse, data keeps its previous value, then 0x55 is received correctly after the line returns high.
- Assert rst during the 4th data bit of 0x81 -> all outputs return to reset values the next cycle. The following clean frame 0x81 yields valid with data=0x81.
- (UART_RX_PARITY_EN) 0x07 with parity bit 1 -> valid, data=0x07. 0x07 with parity bit 0 -> parity_err pulse, no valid.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receiver: 8N1 serial in, parallel byte out, mid-bit sampling from a baud timer.
// Defining UART_RX_PARITY_EN switches the frame to 8E1 and enables parity_err.
`timescale 1ns/1ps
module uart_rx_ctrl #(
  parameter int BAUD        = 115200,
  parameter int CLOCK_SPEED = 100_000_000,
  parameter int CNTR_WIDTH  = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int BIT_TIMER  = CLOCK_SPEED / BAUD;
  localparam int HALF_TIMER = BIT_TIMER / 2;
  localparam logic [CNTR_WIDTH-1:0] BIT_LAST = CNTR_WIDTH'(BIT_TIMER - 1);
  localparam logic [CNTR_WIDTH-1:0] HALF_CNT = CNTR_WIDTH'(HALF_TIMER);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t                  state;
  logic [1:0]              sync_q;
  logic                    rx_s;
  logic [CNTR_WIDTH-1:0]   timer;
  logic [2:0]              bit_index;
  logic [7:0]              shift;
`ifdef UART_RX_PARITY_EN
  logic                    par_bit;
  logic                    parity_err_q;
`endif

  assign rx_s = sync_q[1];

`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  // NOTE: every register here uses <= so all branches see pre-edge values of state, timer and rx_s.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Synchronizer resets to the idle-high line level so reset never fakes a start bit.
      sync_q     <= 2'b11;
      state      <= IDLE;
      timer      <= '0;
      bit_index  <= '0;
      shift      <= '0;
      data       <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync_q    <= {sync_q[0], uart_rx};
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          timer     <= '0;
          bit_index <= '0;
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (timer == HALF_CNT) begin
            timer <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        DATA: begin
          if (timer == BIT_LAST) begin
            timer     <= '0;
            shift     <= {rx_s, shift[7:1]};
            bit_index <= bit_index + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bit_index == 3'd7) state <= PARITY;
`else
            if (bit_index == 3'd7) state <= STOP;
`endif
          end else begin
            timer <= timer + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (timer == BIT_LAST) begin
            timer   <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif

        STOP: begin
          if (timer == BIT_LAST) begin
            timer <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
              if (^{shift, par_bit}) begin
                parity_err_q <= 1'b1;
              end else begin
                data  <= shift;
                valid <= 1'b1;
              end
`else
              data  <= shift;
              valid <= 1'b1;
`endif
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        // A held-low line parks here so it yields one frame_err, not a stream of frames.
        BREAK: begin
          timer <= '0;
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          timer     <= '0;
          bit_index <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus random bytes against a frame-level model.
// Define UART_RX_PARITY_EN for both files to exercise the 8E1 build.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  localparam int CLOCK_SPEED = 1_000_000;
  localparam int BAUD        = 100_000;
  localparam int BIT         = CLOCK_SPEED / BAUD;
  localparam int HALF        = BIT / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Pin falling edge to valid: sync (2) + idle decision (1) + half bit + remaining bit periods.
  localparam int LATENCY = 3 + HALF + (NBITS - 1) * BIT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  uart_rx_ctrl #(
    .BAUD       (BAUD),
    .CLOCK_SPEED(CLOCK_SPEED),
    .CNTR_WIDTH (18)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Observation side: every pulse seen at the falling edge is logged.
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int   n_fe = 0;
  int   n_pe = 0;
  int   n_overlap = 0;
  int   valid_cyc = 0;
  logic busy_at_valid = 1'b1;

  always @(negedge clk) begin
    if (valid) begin
      got_q.push_back(data);
      valid_cyc     = cyc;
      busy_at_valid = busy;
    end
    if (frame_err) n_fe++;
    if (parity_err) n_pe++;
    if (valid && frame_err) n_overlap++;
  end

  int vectors = 0;
  int miscompares = 0;
  int fall_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (BIT) @(negedge clk);
  endtask

  // Serial frame at the pin, LSB first; par_flip inverts the even-parity bit when present.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`endif
    drive_bit(stop_bit);
    uart_rx = 1'b1;
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() != 0) begin
      logic [7:0] e;
      logic [7:0] g;
      e = exp_q.pop_front();
      g = (got_q.size() != 0) ? got_q.pop_front() : 8'hxx;
      check({tag, "_byte"}, g, e);
    end
    got_q.delete();
  endtask

  initial begin
    int lat;
    int fe0;
    int pe0;
    logic [7:0] b;

    // Reset state.
    rst = 1'b1;
    idle(5);
    check("rst_data", data, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    rst = 1'b0;

    // Idle line high.
    idle(100);
    check("idle_data", data, 8'h00);
    check("idle_busy", busy, 1'b0);
    check("idle_fe", n_fe, 0);
    check_stream("idle");

    // Single frame and latency.
    send_frame(8'hA5, 1'b1, 1'b0);
    exp_q.push_back(8'hA5);
    idle(5);
    check_stream("a5");
    check("a5_data", data, 8'hA5);
    check("a5_busy_at_valid", busy_at_valid, 1'b0);
    lat = valid_cyc - fall_cyc;
    check("a5_latency_window", (lat >= LATENCY - 1) && (lat <= LATENCY + 1), 1'b1);

    // Back-to-back frames, no gap.
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    idle(5);
    check_stream("b2b");
    check("b2b_fe", n_fe, 0);

    // Short glitch: false start.
    uart_rx = 1'b0;
    idle(3);
    uart_rx = 1'b1;
    idle(8);
    check("glitch_busy", busy, 1'b0);
    idle(20);
    check_stream("glitch");
    check("glitch_fe", n_fe, 0);

    // Bad stop bit then break.
    fe0 = n_fe;
    send_frame(8'h3C, 1'b0, 1'b0);
    uart_rx = 1'b0;
    idle(50);
    check("brk_fe_once", n_fe - fe0, 1);
    check("brk_data_kept", data, 8'hFF);
    check("brk_busy", busy, 1'b1);
    uart_rx = 1'b1;
    idle(20);
    check("brk_busy_clear", busy, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    exp_q.push_back(8'h55);
    idle(5);
    check_stream("after_brk");
    check("after_brk_fe", n_fe - fe0, 1);

    // Reset during the 4th data bit of 0x81.
    b = 8'h81;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(b[i]);
    uart_rx = b[3];
    idle(5);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_data", data, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_valid", valid, 1'b0);
    check("mid_rst_ferr", frame_err, 1'b0);
    rst = 1'b0;
    uart_rx = 1'b1;
    idle(30);
    check_stream("mid_rst_nopulse");
    send_frame(8'h81, 1'b1, 1'b0);
    exp_q.push_back(8'h81);
    idle(5);
    check_stream("post_rst");
    check("post_rst_data", data, 8'h81);

`ifdef UART_RX_PARITY_EN
    pe0 = n_pe;
    send_frame(8'h07, 1'b1, 1'b0);
    exp_q.push_back(8'h07);
    idle(5);
    check_stream("par_good");
    check("par_good_pe", n_pe - pe0, 0);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(5);
    check_stream("par_bad");
    check("par_bad_pe", n_pe - pe0, 1);
    check("par_bad_data", data, 8'h07);
`else
    pe0 = 0;
    check("no_parity_pe", n_pe, pe0);
`endif

    // Random bytes back-to-back.
    fe0 = n_fe;
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 1'b0);
      exp_q.push_back(b);
    end
    idle(5);
    check_stream("rand");
    check("rand_fe", n_fe - fe0, 0);
    check("valid_ferr_overlap", n_overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
